// File: rtl/edge_event_counter.sv
// Multi-channel edge detector: each detected edge is queued in a per-channel
// saturating pending counter and drained through a per-channel valid/ready handshake.
module edge_event_counter #(
  parameter int NUM_CHANNELS = 4,
  parameter int CNT_WIDTH    = 4,
  parameter int EDGE_MODE    = 0
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             en_i,
  input  logic [NUM_CHANNELS-1:0]          level_i,
  output logic [NUM_CHANNELS-1:0]          edge_o,
  input  logic [NUM_CHANNELS-1:0]          ready_i,
  output logic [NUM_CHANNELS*CNT_WIDTH-1:0] pending_o,
  output logic [NUM_CHANNELS-1:0]          overflow_o,
  input  logic [NUM_CHANNELS-1:0]          clr_ovf_i
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [NUM_CHANNELS-1:0] level_q;
  logic [NUM_CHANNELS-1:0] ovf_q;
  logic                    prime_q;
  logic [CNT_WIDTH-1:0]    cnt_q [NUM_CHANNELS];
  logic [CNT_WIDTH-1:0]    cnt_d [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] sat_d;

  logic [NUM_CHANNELS-1:0] rise;
  logic [NUM_CHANNELS-1:0] fall;
  logic [NUM_CHANNELS-1:0] det;
  logic [NUM_CHANNELS-1:0] ev;
  logic [NUM_CHANNELS-1:0] pop;

  // Returns {saturated, next_count}; a simultaneous event and pop cancel out.
  function automatic logic [CNT_WIDTH:0] next_count(input logic [CNT_WIDTH-1:0] cnt,
                                                    input logic ev_in,
                                                    input logic pop_in);
    logic [CNT_WIDTH:0] res;
    res = {1'b0, cnt};
    if (ev_in && !pop_in) begin
      if (cnt == CNT_MAX) res = {1'b1, cnt};
      else                res = {1'b0, cnt + CNT_ONE};
    end else if (pop_in && !ev_in) begin
      res = {1'b0, cnt - CNT_ONE};
    end
    return res;
  endfunction

  assign rise = level_i & ~level_q;
  assign fall = ~level_i & level_q;

  always_comb begin
    det = '0;
    case (EDGE_MODE)
      0:       det = rise;
      1:       det = fall;
      2:       det = rise | fall;
      default: det = '0;
    endcase
  end

  // prime_q masks the spurious edge seen against the cleared level_q right after reset.
  assign ev  = det & {NUM_CHANNELS{en_i & prime_q}};
  assign pop = edge_o & ready_i;

  always_comb begin
    cnt_d = cnt_q;
    sat_d = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      {sat_d[k], cnt_d[k]} = next_count(cnt_q[k], ev[k], pop[k]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      level_q <= '0;
      prime_q <= 1'b0;
      ovf_q   <= '0;
      for (int k = 0; k < NUM_CHANNELS; k++) cnt_q[k] <= '0;
    end else begin
      level_q <= level_i;
      prime_q <= 1'b1;
      ovf_q   <= sat_d | (ovf_q & ~clr_ovf_i);
      for (int k = 0; k < NUM_CHANNELS; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  for (genvar k = 0; k < NUM_CHANNELS; k++) begin : g_out
    assign edge_o[k] = (cnt_q[k] != '0);
    assign pending_o[k*CNT_WIDTH +: CNT_WIDTH] = cnt_q[k];
  end

  assign overflow_o = ovf_q;

  mode_legal: assert property (@(posedge clk_i) (EDGE_MODE >= 0) && (EDGE_MODE <= 2));

endmodule

// File: tb/tb_edge_event_counter.sv
// Scoreboard bench for edge_event_counter: three instances (rising, falling, both edges)
// driven by directed vectors; expectations are queued per cycle and checked by a monitor.
module tb_edge_event_counter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  level [3];
  logic [3:0]  ready [3];
  logic [3:0]  clr   [3];
  logic        en    [3];
  logic [3:0]  edge_w [3];
  logic [3:0]  ovf_w  [3];
  logic [15:0] pend_w [3];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    edge_event_counter #(
      .NUM_CHANNELS(4),
      .CNT_WIDTH(4),
      .EDGE_MODE(g)
    ) u_dut (
      .clk_i(clk),
      .rst_i(rst),
      .en_i(en[g]),
      .level_i(level[g]),
      .edge_o(edge_w[g]),
      .ready_i(ready[g]),
      .pending_o(pend_w[g]),
      .overflow_o(ovf_w[g]),
      .clr_ovf_i(clr[g])
    );
  end

  typedef struct packed {
    int          cyc;
    logic [1:0]  inst;
    logic [3:0]  e;
    logic [15:0] p;
    logic [3:0]  o;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    cyc    = 0;
  int    checks = 0;
  int    errors = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_next(input int i, input logic [3:0] e, input logic [15:0] p,
                             input logic [3:0] o, input string n);
    exp_t x;
    x.cyc  = cyc + 1;
    x.inst = 2'(i);
    x.e    = e;
    x.p    = p;
    x.o    = o;
    exp_q.push_back(x);
    name_q.push_back(n);
  endtask

  task automatic expect_all_zero(input string n);
    for (int i = 0; i < 3; i++) expect_next(i, 4'h0, 16'h0000, 4'h0, n);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      level[i] = 4'h0; ready[i] = 4'h0; clr[i] = 4'h0; en[i] = 1'b1;
    end
    expect_all_zero("reset");
    tick();
    rst = 1'b0;
  endtask

  initial begin : monitor
    exp_t  x;
    string n;
    forever begin
      @(negedge clk);
      while (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        x = exp_q.pop_front();
        n = name_q.pop_front();
        checks++;
        if (x.cyc != cyc) begin
          errors++;
          $display("FAIL %s inst%0d: checked in cycle %0d, required cycle %0d", n, x.inst, cyc, x.cyc);
        end else if (edge_w[x.inst] !== x.e || pend_w[x.inst] !== x.p || ovf_w[x.inst] !== x.o) begin
          errors++;
          $display("FAIL %s inst%0d cyc%0d: edge=%b pending=%h overflow=%b, required edge=%b pending=%h overflow=%b",
                   n, x.inst, cyc, edge_w[x.inst], pend_w[x.inst], ovf_w[x.inst], x.e, x.p, x.o);
        end
      end
    end
  end

  initial begin : stimulus
    int c, c2, c3;
    logic t;

    // Levels already high through reset must never produce an event.
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      level[i] = 4'hF; ready[i] = 4'h0; clr[i] = 4'h0; en[i] = 1'b1;
    end
    tick();
    expect_all_zero("reset_state");
    tick();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      expect_all_zero("prime");
      tick();
    end

    // Latency and handshake, rising-edge instance.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      expect_next(0, 4'h0, 16'h0000, 4'h0, "lat_idle");
      tick();
    end
    level[0] = 4'b0001;
    expect_next(0, 4'b0001, 16'h0001, 4'h0, "lat_rise");
    tick();
    for (int k = 0; k < 2; k++) begin
      expect_next(0, 4'b0001, 16'h0001, 4'h0, "lat_hold");
      tick();
    end
    ready[0] = 4'b0001;
    expect_next(0, 4'h0, 16'h0000, 4'h0, "lat_pop");
    tick();
    expect_next(0, 4'h0, 16'h0000, 4'h0, "ready_no_edge");
    tick();
    level[0] = 4'b0000;
    expect_next(0, 4'h0, 16'h0000, 4'h0, "rise_mode_ignores_fall");
    tick();
    ready[0] = 4'b0000;

    // Burst and saturation, both-edge instance, channel 1.
    for (int i = 0; i < 20; i++) begin
      level[2] = {2'b00, (i % 2 == 0), 1'b0};
      c = (i + 1 > 15) ? 15 : i + 1;
      expect_next(2, 4'b0010, {8'h00, 4'(c), 4'h0}, (i >= 15) ? 4'b0010 : 4'b0000, "burst");
      tick();
    end
    clr[2] = 4'b0010;
    expect_next(2, 4'b0010, 16'h00F0, 4'h0, "clr_ovf");
    tick();
    clr[2] = 4'b0000;
    expect_next(2, 4'b0010, 16'h00F0, 4'h0, "clr_hold");
    tick();

    // Event and pop together at max: no change, no overflow; then drain.
    level[2] = 4'b0010;
    ready[2] = 4'b0010;
    expect_next(2, 4'b0010, 16'h00F0, 4'h0, "ev_pop_max");
    tick();
    for (int j = 1; j <= 15; j++) begin
      expect_next(2, (15 - j != 0) ? 4'b0010 : 4'b0000, {8'h00, 4'(15 - j), 4'h0}, 4'h0, "drain");
      tick();
    end
    ready[2] = 4'b0000;

    // Falling-edge instance with enable gating.
    en[1] = 1'b1; level[1] = 4'b0001;
    expect_next(1, 4'h0, 16'h0000, 4'h0, "fall_mode_ignores_rise");
    tick();
    en[1] = 1'b0; level[1] = 4'b0000;
    expect_next(1, 4'h0, 16'h0000, 4'h0, "fall_while_disabled");
    tick();
    en[1] = 1'b1;
    expect_next(1, 4'h0, 16'h0000, 4'h0, "enable_toggle");
    tick();
    level[1] = 4'b0001;
    expect_next(1, 4'h0, 16'h0000, 4'h0, "fall_mode_rise2");
    tick();
    level[1] = 4'b0000;
    expect_next(1, 4'b0001, 16'h0001, 4'h0, "fall_counted");
    tick();
    expect_next(1, 4'b0001, 16'h0001, 4'h0, "fall_hold");
    tick();

    // Fill channels 2 and 3 to overflow, drain to 7 and 3, then reset mid-burst.
    for (int i = 0; i < 16; i++) begin
      t = (i % 2 == 0);
      level[2] = {t, t, 1'b1, 1'b0};
      c = (i + 1 > 15) ? 15 : i + 1;
      expect_next(2, 4'b1100, {4'(c), 4'(c), 8'h00}, (i >= 15) ? 4'b1100 : 4'b0000, "mid_fill");
      tick();
    end
    for (int j = 0; j < 12; j++) begin
      ready[2] = {1'b1, (j < 8), 2'b00};
      c2 = 15 - ((j + 1 > 8) ? 8 : j + 1);
      c3 = 15 - (j + 1);
      expect_next(2, 4'b1100, {4'(c3), 4'(c2), 8'h00}, 4'b1100, "mid_drain");
      tick();
    end
    ready[2] = 4'b0000;
    rst = 1'b1;
    level[2] = 4'b1110;
    expect_all_zero("mid_reset");
    tick();
    rst = 1'b0;
    expect_all_zero("post_reset_prime");
    tick();
    expect_all_zero("post_reset_hold");
    tick();

    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
